usb_fifo_bridge: RTL

Second-generation bridge between an FT245-style USB byte FIFO and the on-board user register/memory bus. It parses "HE"-framed command packets and performs multi-word writes or reads of DATA_BYTES-wide words at ADDR_BYTES-wide addresses on the user bus. Compared with the previous interface, it adds:
- parametrised widths and strobe timing;
- header resynchronisation;
- a fixed-address (FIFO-port) mode;
- a mid-packet timeout;
- an optional write acknowledge.

---
 rtl/usb_fifo_bridge.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : usb_fifo_bridge
// Brief    : FT245-style USB byte FIFO to user bus bridge; parses "HE"-framed
//            multi-word read/write packets. Define USB_WRITE_ACK_EN to return
//            a 0x4B byte after every write packet.
// Revision : 1.0 - initial release
// ============================================================================
module usb_fifo_bridge #(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_BYTES  = 2,
  parameter int STROBE_CYC  = 2,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    CK50,
  input  logic                    RESETb,
  input  logic                    USB_RXFb,
  input  logic                    USB_TXEb,
  output logic                    USB_RDb,
  output logic                    USB_WR,
  input  logic [7:0]              USB_DIN,
  output logic [7:0]              USB_DOUT,
  output logic                    USB_DOE,
  output logic [8*ADDR_BYTES-1:0] USER_ADDR,
  output logic [8*DATA_BYTES-1:0] USER_WDATA,
  input  logic [8*DATA_BYTES-1:0] USER_RDATA,
  output logic                    USER_WEb,
  output logic                    USER_REb,
  output logic                    USER_OEb,
  output logic [7:0]              USER_CEb,
  output logic                    FSM0b,
  output logic                    ERR_TIMEOUT
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int AW = 8 * ADDR_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]    STB      = 4'(STROBE_CYC);
  localparam logic [3:0]    LAT      = 4'(RD_LAT);
  localparam logic [3:0]    LAST_A   = 4'(ADDR_BYTES - 1);
  localparam logic [3:0]    LAST_D   = 4'(DATA_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    HDR_0    = 8'h48;
  localparam logic [7:0]    HDR_1    = 8'h45;
  localparam logic [7:0]    ACK_BYTE = 8'h4B;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR1, S_CMD, S_CNT, S_CE, S_ADDR, S_WDATA,
    S_WSTB, S_RSTB, S_RCAP, S_TXB, S_ACK, S_ADV
  } state_t;

`ifdef USB_WRITE_ACK_EN
  localparam state_t WR_END = S_ACK;
`else
  localparam state_t WR_END = S_IDLE;
`endif

  state_t          state_q, state_d;
  logic [1:0]      ph_q, ph_d;
  logic [3:0]      cnt_q, cnt_d, gap_q, gap_d, bidx_q, bidx_d;
  logic [7:0]      rem_q, rem_d;
  logic            dir_q, dir_d, fix_q, fix_d, rxf_q, txe_q;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   rbuf_q, rbuf_d, user_wdata_q, user_wdata_d;
  logic [AW-1:0]   user_addr_q, user_addr_d;
  logic [7:0]      usb_dout_q, usb_dout_d, user_ceb_q, user_ceb_d;
  logic            usb_rdb_q, usb_rdb_d, usb_wr_q, usb_wr_d, usb_doe_q, usb_doe_d;
  logic            user_web_q, user_web_d, user_reb_q, user_reb_d;
  logic            user_oeb_q, user_oeb_d, fsm0b_q, fsm0b_d, err_q, err_d;
  logic            w_rx_done, w_tx_done, w_wait, w_cap;
  logic [7:0]      w_tx_byte;

  always_comb begin
    state_d = state_q;  ph_d = ph_q;  cnt_d = cnt_q;  bidx_d = bidx_q;
    gap_d   = (gap_q != 4'd0) ? gap_q - 4'd1 : gap_q;
    rem_d   = rem_q;  dir_d = dir_q;  fix_d = fix_q;  tmo_d = tmo_q;  rbuf_d = rbuf_q;
    user_addr_d = user_addr_q;  user_wdata_d = user_wdata_q;  user_ceb_d = user_ceb_q;
    usb_dout_d  = usb_dout_q;   usb_rdb_d = usb_rdb_q;  usb_wr_d = usb_wr_q;
    usb_doe_d   = usb_doe_q;    user_web_d = user_web_q;
    user_reb_d  = user_reb_q;   user_oeb_d = user_oeb_q;
    err_d = 1'b0;  w_rx_done = 1'b0;  w_tx_done = 1'b0;  w_wait = 1'b0;  w_cap = 1'b0;
    w_tx_byte = (state_q == S_ACK) ? ACK_BYTE : rbuf_q[DW-1 -: 8];

    // Receive engine: strobe USB_RDb, capture on its last low clock, then enforce the gap
    if (state_q inside {S_IDLE, S_HDR1, S_CMD, S_CNT, S_CE, S_ADDR, S_WDATA}) begin
      if (!usb_rdb_q) begin
        if (cnt_q == 4'd1) begin
          usb_rdb_d = 1'b1;  gap_d = STB;  w_rx_done = 1'b1;
        end else cnt_d = cnt_q - 4'd1;
      end else if (gap_q == 4'd0) begin
        if (!rxf_q) begin usb_rdb_d = 1'b0;  cnt_d = STB; end
        else w_wait = 1'b1;
      end
    end

    if (state_q inside {S_TXB, S_ACK}) begin
      case (ph_q)
        2'd0: if (gap_q == 4'd0) begin
          if (!txe_q) begin usb_dout_d = w_tx_byte;  usb_doe_d = 1'b1;  ph_d = 2'd1; end
          else w_wait = 1'b1;
        end
        2'd1: begin usb_wr_d = 1'b1;  cnt_d = STB;  ph_d = 2'd2; end
        2'd2: if (cnt_q == 4'd1) begin usb_wr_d = 1'b0;  ph_d = 2'd3; end
              else cnt_d = cnt_q - 4'd1;
        default: begin usb_doe_d = 1'b0;  gap_d = STB;  ph_d = 2'd0;  w_tx_done = 1'b1; end
      endcase
    end

    case (state_q)
      S_IDLE:  if (w_rx_done && USB_DIN == HDR_0) state_d = S_HDR1;
      S_HDR1:  if (w_rx_done)
                 state_d = (USB_DIN == HDR_1) ? S_CMD : (USB_DIN == HDR_0) ? S_HDR1 : S_IDLE;
      S_CMD:   if (w_rx_done) begin dir_d = USB_DIN[7];  fix_d = USB_DIN[6];  state_d = S_CNT; end
      S_CNT:   if (w_rx_done) begin rem_d = USB_DIN;  state_d = S_CE; end
      S_CE:    if (w_rx_done) begin user_ceb_d = USB_DIN;  bidx_d = 4'd0;  state_d = S_ADDR; end
      S_ADDR:  if (w_rx_done) begin
        user_addr_d = (user_addr_q << 8) | AW'(USB_DIN);
        bidx_d = bidx_q + 4'd1;
        if (bidx_q == LAST_A) begin
          bidx_d  = 4'd0;
          state_d = (rem_q == 8'd0) ? (dir_q ? S_IDLE : WR_END) : (dir_q ? S_RSTB : S_WDATA);
        end
      end
      S_WDATA: if (w_rx_done) begin
        user_wdata_d = (user_wdata_q << 8) | DW'(USB_DIN);
        bidx_d = bidx_q + 4'd1;
        if (bidx_q == LAST_D) begin bidx_d = 4'd0;  ph_d = 2'd0;  state_d = S_WSTB; end
      end
      // Setup clock, one-clock WEb low, hold clock
      S_WSTB:  case (ph_q)
        2'd0:    begin user_web_d = 1'b0;  ph_d = 2'd1; end
        2'd1:    begin user_web_d = 1'b1;  ph_d = 2'd2; end
        default: begin ph_d = 2'd0;  state_d = S_ADV; end
      endcase
      S_RSTB:  if (ph_q == 2'd0) begin
        user_reb_d = 1'b0;  user_oeb_d = 1'b0;  cnt_d = LAT;  ph_d = 2'd1;
      end else begin
        user_reb_d = 1'b1;  user_oeb_d = 1'b1;  ph_d = 2'd0;  state_d = S_RCAP;  w_cap = 1'b1;
      end
      S_RCAP:  w_cap = 1'b1;
      S_TXB:   if (w_tx_done) begin
        rbuf_d = rbuf_q << 8;
        bidx_d = bidx_q + 4'd1;
        if (bidx_q == LAST_D) begin bidx_d = 4'd0;  state_d = S_ADV; end
      end
      S_ACK:   if (w_tx_done) state_d = S_IDLE;
      S_ADV:   begin
        rem_d = rem_q - 8'd1;
        if (!fix_q) user_addr_d = user_addr_q + AW'(1);
        state_d = (rem_q == 8'd1) ? (dir_q ? S_IDLE : WR_END) : (dir_q ? S_RSTB : S_WDATA);
      end
      default: state_d = S_IDLE;
    endcase

    // Capture lands RD_LAT clocks after the USER_REb falling edge
    if (w_cap) begin
      if (cnt_q == 4'd1) begin rbuf_d = USER_RDATA;  bidx_d = 4'd0;  state_d = S_TXB; end
      else cnt_d = cnt_q - 4'd1;
    end

    if (w_wait && !(state_q inside {S_IDLE, S_HDR1})) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;  err_d = 1'b1;  ph_d = 2'd0;  bidx_d = 4'd0;
        usb_rdb_d = 1'b1;  usb_wr_d = 1'b0;  usb_doe_d = 1'b0;
        user_web_d = 1'b1;  user_reb_d = 1'b1;  user_oeb_d = 1'b1;
      end else tmo_d = tmo_q + TW'(1);
    end else tmo_d = '0;

    if (state_d == S_IDLE) user_ceb_d = 8'hFF;
    fsm0b_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CK50) begin
    if (!RESETb) begin
      state_q <= S_IDLE;  ph_q <= 2'd0;  cnt_q <= 4'd0;  gap_q <= 4'd0;  bidx_q <= 4'd0;
      rem_q <= 8'd0;  dir_q <= 1'b0;  fix_q <= 1'b0;  tmo_q <= '0;  rbuf_q <= '0;
      rxf_q <= 1'b1;  txe_q <= 1'b1;
      user_addr_q <= '0;  user_wdata_q <= '0;  user_ceb_q <= 8'hFF;  usb_dout_q <= 8'd0;
      usb_rdb_q <= 1'b1;  usb_wr_q <= 1'b0;  usb_doe_q <= 1'b0;
      user_web_q <= 1'b1;  user_reb_q <= 1'b1;  user_oeb_q <= 1'b1;
      fsm0b_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  ph_q <= ph_d;  cnt_q <= cnt_d;  gap_q <= gap_d;  bidx_q <= bidx_d;
      rem_q <= rem_d;  dir_q <= dir_d;  fix_q <= fix_d;  tmo_q <= tmo_d;  rbuf_q <= rbuf_d;
      rxf_q <= USB_RXFb;  txe_q <= USB_TXEb;
      user_addr_q <= user_addr_d;  user_wdata_q <= user_wdata_d;  user_ceb_q <= user_ceb_d;
      usb_dout_q <= usb_dout_d;  usb_rdb_q <= usb_rdb_d;  usb_wr_q <= usb_wr_d;
      usb_doe_q <= usb_doe_d;  user_web_q <= user_web_d;  user_reb_q <= user_reb_d;
      user_oeb_q <= user_oeb_d;  fsm0b_q <= fsm0b_d;  err_q <= err_d;
    end
  end

  assign USB_RDb     = usb_rdb_q;
  assign USB_WR      = usb_wr_q;
  assign USB_DOUT    = usb_dout_q;
  assign USB_DOE     = usb_doe_q;
  assign USER_ADDR   = user_addr_q;
  assign USER_WDATA  = user_wdata_q;
  assign USER_WEb    = user_web_q;
  assign USER_REb    = user_reb_q;
  assign USER_OEb    = user_oeb_q;
  assign USER_CEb    = user_ceb_q;
  assign FSM0b       = fsm0b_q;
  assign ERR_TIMEOUT = err_q;

endmodule
`default_nettype wire
